// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches a word, hands it downstream, decodes BEQ/J for
// pc_control_32 and waits for the pc update. Optional REQ/WAIT_PC watchdog: FETCH_TIMEOUT_EN.
module fetch_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  input  logic        cond_valid_i,
  input  logic        cond_taken_i,
  output logic        start_o,
  output logic        beq_o,
  output logic        jump_o,
  output logic [31:0] branch_offset_o,
  output logic [25:0] jump_addr_o,
  input  logic [31:0] pc_i,
  input  logic        finish_i,
  output logic        fault_o
);

  localparam logic [5:0] OpJump = 6'b000010;
  localparam logic [5:0] OpBeq  = 6'b000100;

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [2:0] {StReq, StIssue, StCond, StUpdate, StWaitPc, StHalt} state_e;
  localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
`else
  typedef enum logic [2:0] {StReq, StIssue, StCond, StUpdate, StWaitPc} state_e;
`endif

  state_e      state_q, state_d;
  logic        run_q;
  logic [31:0] pc_q;
  logic        pc_load;
  logic [31:0] instr_q, instr_d;
  logic        beq_q, beq_d;
  logic        jump_q, jump_d;
  logic [31:0] branch_offset_q, branch_offset_d;
  logic [25:0] jump_addr_q, jump_addr_d;

`ifdef FETCH_TIMEOUT_EN
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fault_q, fault_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    beq_d           = beq_q;
    jump_d          = jump_q;
    branch_offset_d = branch_offset_q;
    jump_addr_d     = jump_addr_q;
    pc_load         = 1'b0;

    unique case (state_q)
      StReq: begin
        // run_q is low for the first cycle after reset, so no fetch is issued yet.
        if (run_q && imem_ack_i) begin
          instr_d = imem_data_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (instr_ready_i) begin
          beq_d           = 1'b0;
          jump_d          = (instr_q[31:26] == OpJump);
          jump_addr_d     = instr_q[25:0];
          branch_offset_d = {{16{instr_q[15]}}, instr_q[15:0]};
          state_d         = (instr_q[31:26] == OpBeq) ? StCond : StUpdate;
        end
      end
      StCond: begin
        if (cond_valid_i) begin
          beq_d   = cond_taken_i;
          state_d = StUpdate;
        end
      end
      StUpdate: state_d = StWaitPc;
      StWaitPc: begin
        if (finish_i) begin
          pc_load = 1'b1;
          state_d = StReq;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StReq;
    endcase

`ifdef FETCH_TIMEOUT_EN
    cnt_d   = '0;
    fault_d = fault_q;
    // Counter only runs while parked in a waiting state; any transition clears it.
    if ((state_d == state_q) && (((state_q == StReq) && run_q) || (state_q == StWaitPc))) begin
      if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
        state_d = StHalt;
        fault_d = 1'b1;
        beq_d   = 1'b0;
        jump_d  = 1'b0;
        pc_load = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= StReq;
      run_q           <= 1'b0;
      instr_q         <= '0;
      beq_q           <= 1'b0;
      jump_q          <= 1'b0;
      branch_offset_q <= '0;
      jump_addr_q     <= '0;
    end else begin
      state_q         <= state_d;
      run_q           <= 1'b1;
      instr_q         <= instr_d;
      beq_q           <= beq_d;
      jump_q          <= jump_d;
      branch_offset_q <= branch_offset_d;
      jump_addr_q     <= jump_addr_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
  assign fault_o = fault_q;
`else
  assign fault_o = 1'b0;
`endif

  // pc_q tracks pc while held in reset and on the first edge after release.
  always_ff @(posedge clk_i) begin
    if (reset_i || !run_q || pc_load) begin
      pc_q <= pc_i;
    end
  end

  assign imem_req_o      = run_q && (state_q == StReq);
  assign imem_addr_o     = pc_q;
  assign instr_o         = instr_q;
  assign instr_valid_o   = (state_q == StIssue);
  assign start_o         = (state_q == StUpdate);
  assign beq_o           = beq_q;
  assign jump_o          = jump_q;
  assign branch_offset_o = branch_offset_q;
  assign jump_addr_o     = jump_addr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        cond_valid;
  logic        cond_taken;
  logic        start;
  logic        beq;
  logic        jump;
  logic [31:0] branch_offset;
  logic [25:0] jump_addr;
  logic [31:0] pc;
  logic        finish;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_ack_i      (imem_ack),
    .imem_data_i     (imem_data),
    .instr_o         (instr),
    .instr_valid_o   (instr_valid),
    .instr_ready_i   (instr_ready),
    .cond_valid_i    (cond_valid),
    .cond_taken_i    (cond_taken),
    .start_o         (start),
    .beq_o           (beq),
    .jump_o          (jump),
    .branch_offset_o (branch_offset),
    .jump_addr_o     (jump_addr),
    .pc_i            (pc),
    .finish_i        (finish),
    .fault_o         (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pc    = 32'h0;
    repeat (3) tick();
    n_cmp++;
    if ({imem_req, start, instr_valid, beq, jump, fault} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_strobes: got %b expected 000000",
               {imem_req, start, instr_valid, beq, jump, fault});
    end
    n_cmp++;
    if ({instr, branch_offset, jump_addr} !== 90'b0) begin
      n_err++;
      $display("FAIL reset_data: got %h expected 0", {instr, branch_offset, jump_addr});
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL req_before_edge: got %b expected 0", imem_req);
    end
    tick();
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL first_req: got %b/%h expected 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_seq_fetch();
    instr_ready = 1'b1;
    tick();
    tick();
    imem_data = 32'h0000_0020;
    imem_ack  = 1'b1;
    tick();
    imem_ack = 1'b0;
    n_cmp++;
    if ({imem_req, instr_valid, instr} !== {2'b01, 32'h0000_0020}) begin
      n_err++;
      $display("FAIL seq_issue: got %b%b/%h expected 01/00000020", imem_req, instr_valid, instr);
    end
    tick();
    n_cmp++;
    if ({start, beq, jump, instr_valid} !== 4'b1000) begin
      n_err++;
      $display("FAIL seq_start: got %b expected 1000", {start, beq, jump, instr_valid});
    end
    tick();
    n_cmp++;
    if (start !== 1'b0) begin
      n_err++;
      $display("FAIL seq_start_pulse: got %b expected 0", start);
    end
    pc     = 32'h0000_0004;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0004}) begin
      n_err++;
      $display("FAIL seq_next_pc: got %b/%h expected 1/00000004", imem_req, imem_addr);
    end
  endtask

  task automatic test_jump();
    imem_data   = 32'h0800_03E8;
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    tick();
    imem_ack   = 1'b0;
    cond_valid = 1'b1;
    cond_taken = 1'b1;
    tick();
    cond_valid = 1'b0;
    n_cmp++;
    if ({start, jump, beq, jump_addr} !== {3'b110, 26'd1000}) begin
      n_err++;
      $display("FAIL jump_start: got %b/%0d expected 110/1000", {start, jump, beq}, jump_addr);
    end
    tick();
    n_cmp++;
    if ({start, jump, beq, jump_addr} !== {3'b010, 26'd1000}) begin
      n_err++;
      $display("FAIL jump_hold: got %b/%0d expected 010/1000", {start, jump, beq}, jump_addr);
    end
    pc     = 32'h0000_0008;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0008}) begin
      n_err++;
      $display("FAIL jump_next_pc: got %b/%h expected 1/00000008", imem_req, imem_addr);
    end
  endtask

  task automatic test_beq(input string name, input logic [31:0] data, input logic taken,
                          input logic [31:0] exp_off, input logic [31:0] next_pc);
    imem_data   = data;
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    cond_valid  = 1'b1;
    cond_taken  = ~taken;
    tick();
    imem_ack = 1'b0;
    // cond_valid stays high across the handshake and must not resolve the branch.
    tick();
    cond_valid = 1'b0;
    n_cmp++;
    if ({start, instr_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL %s_cond_ignored: got %b expected 00", name, {start, instr_valid});
    end
    tick();
    tick();
    n_cmp++;
    if (start !== 1'b0) begin
      n_err++;
      $display("FAIL %s_cond_wait: got %b expected 0", name, start);
    end
    cond_valid = 1'b1;
    cond_taken = taken;
    tick();
    cond_valid = 1'b0;
    n_cmp++;
    if ({start, beq, jump, branch_offset} !== {1'b1, taken, 1'b0, exp_off}) begin
      n_err++;
      $display("FAIL %s_start: got %b/%h expected %b/%h", name, {start, beq, jump},
               branch_offset, {1'b1, taken, 1'b0}, exp_off);
    end
    tick();
    n_cmp++;
    if ({start, beq, branch_offset} !== {1'b0, taken, exp_off}) begin
      n_err++;
      $display("FAIL %s_hold: got %b/%h expected %b/%h", name, {start, beq}, branch_offset,
               {1'b0, taken}, exp_off);
    end
    pc     = next_pc;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, next_pc}) begin
      n_err++;
      $display("FAIL %s_next_pc: got %b/%h expected 1/%h", name, imem_req, imem_addr, next_pc);
    end
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b0;
    imem_data   = 32'h0123_4567;
    imem_ack    = 1'b1;
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({instr_valid, start, instr} !== {2'b10, 32'h0123_4567}) begin
        n_err++;
        $display("FAIL bp_stall_%0d: got %b/%h expected 10/01234567", i, {instr_valid, start},
                 instr);
      end
      if (i == 1) begin
        imem_ack  = 1'b1;
        imem_data = 32'hFFFF_FFFF;
        finish    = 1'b1;
        pc        = 32'hDEAD_BEEF;
      end else begin
        imem_ack = 1'b0;
        finish   = 1'b0;
      end
      tick();
    end
    n_cmp++;
    if ({instr_valid, instr} !== {1'b1, 32'h0123_4567}) begin
      n_err++;
      $display("FAIL bp_after_spurious: got %b/%h expected 1/01234567", instr_valid, instr);
    end
    instr_ready = 1'b1;
    tick();
    n_cmp++;
    if (start !== 1'b1) begin
      n_err++;
      $display("FAIL bp_start: got %b expected 1", start);
    end
    tick();
    pc     = 32'h0000_0018;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0018}) begin
      n_err++;
      $display("FAIL bp_next_pc: got %b/%h expected 1/00000018", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    imem_data   = 32'h0800_0001;
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({start, jump} !== 2'b01) begin
      n_err++;
      $display("FAIL rm_wait_pc: got %b expected 01", {start, jump});
    end
    pc     = 32'h0000_0200;
    reset  = 1'b1;
    finish = 1'b1;
    #1;
    n_cmp++;
    if ({start, imem_req, instr_valid, jump, beq, fault} !== 6'b0) begin
      n_err++;
      $display("FAIL rm_strobes: got %b expected 000000",
               {start, imem_req, instr_valid, jump, beq, fault});
    end
    n_cmp++;
    if ({instr, branch_offset, jump_addr} !== 90'b0) begin
      n_err++;
      $display("FAIL rm_data: got %h expected 0", {instr, branch_offset, jump_addr});
    end
    tick();
    tick();
    reset  = 1'b0;
    finish = 1'b0;
    tick();
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0200}) begin
      n_err++;
      $display("FAIL rm_restart: got %b/%h expected 1/00000200", imem_req, imem_addr);
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({fault, imem_req} !== 2'b01) begin
        n_err++;
        $display("FAIL to_waiting_%0d: got %b expected 01", i, {fault, imem_req});
      end
    end
    tick();
    n_cmp++;
    if ({fault, imem_req, start, instr_valid} !== 4'b1000) begin
      n_err++;
      $display("FAIL to_halt: got %b expected 1000", {fault, imem_req, start, instr_valid});
    end
    imem_ack = 1'b1;
    tick();
    tick();
    imem_ack = 1'b0;
    n_cmp++;
    if ({fault, imem_req, instr_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL to_sticky: got %b expected 100", {fault, imem_req, instr_valid});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({fault, imem_req} !== 2'b01) begin
      n_err++;
      $display("FAIL to_cleared: got %b expected 01", {fault, imem_req});
    end
  endtask
`else
  task automatic test_no_timeout();
    repeat (300) tick();
    n_cmp++;
    if ({fault, imem_req, instr_valid} !== 3'b010) begin
      n_err++;
      $display("FAIL no_timeout: got %b expected 010", {fault, imem_req, instr_valid});
    end
  endtask
`endif

  initial begin
    reset       = 1'b1;
    imem_ack    = 1'b0;
    imem_data   = 32'h0;
    instr_ready = 1'b0;
    cond_valid  = 1'b0;
    cond_taken  = 1'b0;
    pc          = 32'h0;
    finish      = 1'b0;

    test_reset();
    test_seq_fetch();
    test_jump();
    test_beq("beq_taken", 32'h1000_07D0, 1'b1, 32'h0000_07D0, 32'h0000_000C);
    test_beq("beq_not_taken", 32'h1000_07D0, 1'b0, 32'h0000_07D0, 32'h0000_0010);
    test_beq("beq_neg", 32'h1000_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
    test_backpressure();
    test_reset_mid();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
